// File: rtl/sys_bus.sv
// sys_bus: registered request/acknowledge engine between the CPU data port and
// NUM_SLV peripheral slots, with access timeout and bus-error logging.
module sys_bus #(
    parameter int NUM_SLV = 4,
    parameter int SEL_LO  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wd,
    output logic [31:0]           cpu_rd,
    output logic                  cpu_ready,
    output logic                  cpu_err,
    output logic [NUM_SLV-1:0]    s_req,
    output logic                  s_we,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wd,
    input  logic [NUM_SLV*32-1:0] s_rd,
    input  logic [NUM_SLV-1:0]    s_ack,
    output logic [31:0]           err_addr,
    output logic [7:0]            err_cnt
);
    localparam int              SELW       = $clog2(NUM_SLV);
    localparam logic [SELW:0]   SLOT_LIMIT = (SELW+1)'(NUM_SLV);
    localparam logic [7:0]      TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0]     ERR_DATA   = 32'hDEAD_BEEF;

    // state  | meaning
    // IDLE   | waiting for cpu_req
    // ACCESS | s_req held on the selected slot, timer running
    // DONE   | single-cycle cpu_ready / cpu_err completion
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_next;
    logic [SELW-1:0]    slot_q;
    logic [SELW-1:0]    req_slot;
    logic [SELW-1:0]    cur_slot;
    logic [7:0]         timer;
    logic               start;
    logic               mapped;
    logic               ack_hit;
    logic               done_err;
    logic               err_we;
    logic [31:0]        rd_sel;
    logic [31:0]        err_src;
    logic [NUM_SLV-1:0] req_onehot;

    assign req_slot = cpu_addr[SEL_LO +: SELW];
    assign mapped   = {1'b0, req_slot} < SLOT_LIMIT;
    assign cur_slot = (state == IDLE) ? req_slot : slot_q;

    // An unmapped access errors in the same edge it is latched, so the error
    // bookkeeping must look at the CPU side rather than the latched copies.
    assign err_we  = (state == IDLE) ? cpu_we   : s_we;
    assign err_src = (state == IDLE) ? cpu_addr : s_addr;

    always_comb begin
        req_onehot = '0;
        rd_sel     = '0;
        ack_hit    = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (cur_slot == SELW'(i)) begin
                req_onehot[i] = 1'b1;
                rd_sel        = s_rd[32*i +: 32];
                ack_hit       = s_ack[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    start = 1'b1;
                    if (mapped) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = DONE;
                        done_err   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // ack has priority over a timeout landing on the same edge
                if (ack_hit) begin
                    state_next = DONE;
                end else if (timer == TIMER_LAST) begin
                    state_next = DONE;
                    done_err   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rd    <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            s_req     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wd      <= '0;
            slot_q    <= '0;
            timer     <= '0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else begin
            cpu_ready <= (state_next == DONE);
            cpu_err   <= done_err;
            s_req     <= (state_next == ACCESS) ? req_onehot : '0;

            if (start) begin
                s_we   <= cpu_we;
                s_addr <= cpu_addr;
                s_wd   <= cpu_wd;
                slot_q <= req_slot;
                timer  <= '0;
            end else if (state == ACCESS) begin
                timer <= timer + 8'd1;
            end

            if (state == ACCESS && ack_hit && !s_we) begin
                cpu_rd <= rd_sel;
            end

            if (done_err) begin
                if (!err_we) begin
                    cpu_rd <= ERR_DATA;
                end
                err_addr <= err_src;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sys_bus.sv
// Testbench for sys_bus: scenario tasks with a queue of expected completions.
module tb_sys_bus;
    localparam int NS  = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wd;
    logic [31:0]       cpu_rd;
    logic              cpu_ready;
    logic              cpu_err;
    logic [NS-1:0]     s_req;
    logic              s_we;
    logic [31:0]       s_addr;
    logic [31:0]       s_wd;
    logic [NS*32-1:0]  s_rd;
    logic [NS-1:0]     s_ack;
    logic [31:0]       err_addr;
    logic [7:0]        err_cnt;

    logic              req3;
    logic              we3;
    logic [31:0]       addr3;
    logic [31:0]       wd3;
    logic [31:0]       rd3;
    logic              ready3;
    logic              err3;
    logic [2:0]        s_req3;
    logic              s_we3;
    logic [31:0]       s_addr3;
    logic [31:0]       s_wd3;
    logic [95:0]       s_rd3;
    logic [2:0]        s_ack3;
    logic [31:0]       err_addr3;
    logic [7:0]        err_cnt3;

    sys_bus #(.NUM_SLV(NS), .SEL_LO(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
        .cpu_ready(cpu_ready), .cpu_err(cpu_err), .s_req(s_req), .s_we(s_we),
        .s_addr(s_addr), .s_wd(s_wd), .s_rd(s_rd), .s_ack(s_ack),
        .err_addr(err_addr), .err_cnt(err_cnt)
    );

    sys_bus #(.NUM_SLV(3), .SEL_LO(8), .TIMEOUT(TMO)) dut3 (
        .clk(clk), .rst(rst), .cpu_req(req3), .cpu_we(we3),
        .cpu_addr(addr3), .cpu_wd(wd3), .cpu_rd(rd3),
        .cpu_ready(ready3), .cpu_err(err3), .s_req(s_req3), .s_we(s_we3),
        .s_addr(s_addr3), .s_wd(s_wd3), .s_rd(s_rd3), .s_ack(s_ack3),
        .err_addr(err_addr3), .err_cnt(err_cnt3)
    );

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Runs one access starting from IDLE; lat = cycles after the request edge
    // at which cpu_ready was seen (0 = never within the budget).
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [NS-1:0] ack_mask, input int ack_first, input int ack_last,
                              input int rst_at, output int lat, output logic err,
                              output logic [31:0] rd, output int req_cycles,
                              output logic [NS-1:0] req_seen, output logic stable);
        lat = 0; err = 1'b0; rd = '0; req_cycles = 0; req_seen = '0; stable = 1'b1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int c = 1; c <= TMO + 4; c++) begin
            if (c >= ack_first && c <= ack_last) s_ack = ack_mask;
            if (c == rst_at) rst = 1'b1;
            @(negedge clk);
            if (cpu_ready && lat == 0) begin
                lat = c; err = cpu_err; rd = cpu_rd;
            end
            if (s_req != '0) begin
                req_cycles++;
                req_seen |= s_req;
            end
            if ((s_req != '0 || cpu_ready) && (s_addr !== addr || s_wd !== wd || s_we !== we))
                stable = 1'b0;
            @(posedge clk); #1;
            s_ack = '0;
            rst = 1'b0;
            if (lat != 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_rd !== 32'h0) $display("FAIL reset cpu_rd got %h want 0", cpu_rd); else n_pass++;
        n_checks++; if (cpu_ready !== 1'b0 || cpu_err !== 1'b0) $display("FAIL reset ready/err got %b%b want 00", cpu_ready, cpu_err); else n_pass++;
        n_checks++; if (s_req !== '0 || s_we !== 1'b0) $display("FAIL reset s_req/s_we got %b/%b want 0/0", s_req, s_we); else n_pass++;
        n_checks++; if (s_addr !== 32'h0 || s_wd !== 32'h0) $display("FAIL reset s_addr/s_wd got %h/%h want 0/0", s_addr, s_wd); else n_pass++;
        n_checks++; if (err_addr !== 32'h0 || err_cnt !== 8'h0) $display("FAIL reset err_addr/err_cnt got %h/%0d want 0/0", err_addr, err_cnt); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_read_fast();
        exp_t e; int lat; logic err; logic [31:0] rd; int reqs; logic [NS-1:0] seen; logic stable;
        s_rd[64 +: 32] = 32'h1234_5678;
        sb.push_back('{lat: 2, err: 1'b0, rd: 32'h1234_5678});
        run_access(1'b0, 32'h0000_0200, 32'h0, 4'b0100, 1, 1, 0, lat, err, rd, reqs, seen, stable);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL read_fast latency got %0d want %0d", lat, e.lat); else n_pass++;
        n_checks++; if (err !== e.err || rd !== e.rd) $display("FAIL read_fast err/rd got %b/%h want %b/%h", err, rd, e.err, e.rd); else n_pass++;
        n_checks++; if (reqs !== 1 || seen !== 4'b0100) $display("FAIL read_fast s_req got %0d cycles %b want 1 cycle 0100", reqs, seen); else n_pass++;
    endtask

    task automatic test_write_delayed();
        exp_t e; int lat; logic err; logic [31:0] rd; int reqs; logic [NS-1:0] seen; logic stable;
        sb.push_back('{lat: 6, err: 1'b0, rd: 32'h1234_5678});
        run_access(1'b1, 32'h0000_0304, 32'hA5A5_A5A5, 4'b1000, 5, 5, 0, lat, err, rd, reqs, seen, stable);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL write_delayed latency got %0d want %0d", lat, e.lat); else n_pass++;
        n_checks++; if (err !== e.err || rd !== e.rd) $display("FAIL write_delayed err/rd got %b/%h want %b/%h", err, rd, e.err, e.rd); else n_pass++;
        n_checks++; if (stable !== 1'b1) $display("FAIL write_delayed stability got %b want 1", stable); else n_pass++;
        n_checks++; if (reqs !== 5 || seen !== 4'b1000) $display("FAIL write_delayed s_req got %0d cycles %b want 5 cycles 1000", reqs, seen); else n_pass++;
    endtask

    task automatic test_timeout();
        exp_t e; int lat; logic err; logic [31:0] rd; int reqs; logic [NS-1:0] seen; logic stable;
        sb.push_back('{lat: TMO + 1, err: 1'b1, rd: 32'hDEAD_BEEF});
        run_access(1'b0, 32'h0000_0108, 32'h0, 4'b0000, 0, -1, 0, lat, err, rd, reqs, seen, stable);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL timeout latency got %0d want %0d", lat, e.lat); else n_pass++;
        n_checks++; if (err !== e.err || rd !== e.rd) $display("FAIL timeout err/rd got %b/%h want %b/%h", err, rd, e.err, e.rd); else n_pass++;
        n_checks++; if (reqs !== TMO || seen !== 4'b0010) $display("FAIL timeout s_req got %0d cycles %b want %0d cycles 0010", reqs, seen, TMO); else n_pass++;
        n_checks++; if (err_addr !== 32'h0000_0108 || err_cnt !== 8'd1) $display("FAIL timeout err_addr/err_cnt got %h/%0d want 00000108/1", err_addr, err_cnt); else n_pass++;
    endtask

    task automatic test_ack_boundary();
        exp_t e; int lat; logic err; logic [31:0] rd; int reqs; logic [NS-1:0] seen; logic stable;
        s_rd[96 +: 32] = 32'hCAFE_0003;
        sb.push_back('{lat: TMO + 1, err: 1'b0, rd: 32'hCAFE_0003});
        run_access(1'b0, 32'h0000_0300, 32'h0, 4'b1000, TMO, TMO, 0, lat, err, rd, reqs, seen, stable);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL ack_last latency got %0d want %0d", lat, e.lat); else n_pass++;
        n_checks++; if (err !== e.err || rd !== e.rd) $display("FAIL ack_last err/rd got %b/%h want %b/%h", err, rd, e.err, e.rd); else n_pass++;
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL ack_last err_cnt got %0d want 1", err_cnt); else n_pass++;

        sb.push_back('{lat: TMO + 1, err: 1'b1, rd: 32'hDEAD_BEEF});
        run_access(1'b0, 32'h0000_0104, 32'h0, 4'b0001, 1, TMO, 0, lat, err, rd, reqs, seen, stable);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL wrong_slot_ack latency got %0d want %0d", lat, e.lat); else n_pass++;
        n_checks++; if (err !== e.err || rd !== e.rd) $display("FAIL wrong_slot_ack err/rd got %b/%h want %b/%h", err, rd, e.err, e.rd); else n_pass++;
        n_checks++; if (err_cnt !== 8'd2 || err_addr !== 32'h0000_0104) $display("FAIL wrong_slot_ack err_cnt/err_addr got %0d/%h want 2/00000104", err_cnt, err_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat; logic err; logic [31:0] rd; int reqs; logic [NS-1:0] seen; logic stable;
        sb.push_back('{lat: 0, err: 1'b0, rd: 32'h0});
        run_access(1'b0, 32'h0000_0204, 32'h0, 4'b0000, 0, -1, 4, lat, err, rd, reqs, seen, stable);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL reset_mid ready got cycle %0d want none", lat); else n_pass++;
        n_checks++; if (reqs !== 4) $display("FAIL reset_mid s_req cycles got %0d want 4", reqs); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0 || err_addr !== 32'h0) $display("FAIL reset_mid err_cnt/err_addr got %0d/%h want 0/0", err_cnt, err_addr); else n_pass++;

        s_rd[0 +: 32] = 32'h0BAD_F00D;
        sb.push_back('{lat: 4, err: 1'b0, rd: 32'h0BAD_F00D});
        run_access(1'b0, 32'h0000_0010, 32'h0, 4'b0001, 3, 3, 0, lat, err, rd, reqs, seen, stable);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL after_reset latency got %0d want %0d", lat, e.lat); else n_pass++;
        n_checks++; if (err !== e.err || rd !== e.rd) $display("FAIL after_reset err/rd got %b/%h want %b/%h", err, rd, e.err, e.rd); else n_pass++;
    endtask

    task automatic test_unmapped();
        exp_t e; int lat; logic err; logic [31:0] rd; int reqs;
        lat = 0; err = 1'b0; rd = '0; reqs = 0;
        sb.push_back('{lat: 1, err: 1'b1, rd: 32'hDEAD_BEEF});
        req3 = 1'b1; we3 = 1'b0; addr3 = 32'h0000_0310;
        @(posedge clk); #1;
        req3 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (s_req3 != '0) reqs++;
            if (ready3 && lat == 0) begin
                lat = c; err = err3; rd = rd3;
            end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL unmapped latency got %0d want %0d", lat, e.lat); else n_pass++;
        n_checks++; if (err !== e.err || rd !== e.rd) $display("FAIL unmapped err/rd got %b/%h want %b/%h", err, rd, e.err, e.rd); else n_pass++;
        n_checks++; if (reqs !== 0) $display("FAIL unmapped s_req cycles got %0d want 0", reqs); else n_pass++;
        n_checks++; if (err_addr3 !== 32'h0000_0310 || err_cnt3 !== 8'd1) $display("FAIL unmapped err_addr/err_cnt got %h/%0d want 00000310/1", err_addr3, err_cnt3); else n_pass++;
    endtask

    task automatic test_saturation();
        int lat; logic err; logic [31:0] rd; int reqs; logic [NS-1:0] seen; logic stable;
        logic [31:0] a;
        for (int i = 1; i <= 256; i++) begin
            a = 32'h0000_0100 | ((i * 4) & 32'hFC);
            run_access(1'b0, a, 32'h0, 4'b0000, 0, -1, 0, lat, err, rd, reqs, seen, stable);
            if (i == 254) begin
                n_checks++; if (err_cnt !== 8'd254) $display("FAIL sat_254 err_cnt got %0d want 254", err_cnt); else n_pass++;
            end
            if (i == 255) begin
                n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_255 err_cnt got %0d want 255", err_cnt); else n_pass++;
            end
        end
        n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_256 err_cnt got %0d want 255", err_cnt); else n_pass++;
        n_checks++; if (err_addr !== a) $display("FAIL sat err_addr got %h want %h", err_addr, a); else n_pass++;
        n_checks++; if (err !== 1'b1 || lat !== TMO + 1) $display("FAIL sat last access err/lat got %b/%0d want 1/%0d", err, lat, TMO + 1); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
        s_ack = '0;
        s_rd = {32'h5100_0003, 32'h5100_0002, 32'h5100_0001, 32'h5100_0000};
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; wd3 = '0; s_ack3 = '0; s_rd3 = '0;

        test_reset();
        test_read_fast();
        test_write_delayed();
        test_timeout();
        test_ack_boundary();
        test_reset_mid();
        test_unmapped();
        test_saturation();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sys_bus.md
# sys_bus

Parametrised memory-mapped bus controller between the MIPS core's data port and `NUM_SLV` peripheral slots: data memory, accelerators, GPIO. It replaces the single-cycle combinational address decoder and read-data mux with a registered request/acknowledge transaction engine. Slaves may take a variable number of cycles to respond. Any access that is never acknowledged ends with a bus error and is recorded for software.

## Interface
- `NUM_SLV`, 4: number of slave slots, 2..8; slot width `SELW` = clog2(`NUM_SLV`).
- `SEL_LO`, 8: lowest address bit of the slot-select field `cpu_addr[SEL_LO+SELW-1:SEL_LO]`.
- `TIMEOUT`, 15: number of ACCESS cycles without an ack before a bus error is raised, 2..255.
- `clk` in 1: single clock; all logic samples on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: access request; sampled only in IDLE.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 32: byte address.
- `cpu_wd` in 32: write data.
- `cpu_rd` out 32: registered read data.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_err` out 1: bus error flag; valid only while `cpu_ready` = 1.
- `s_req` out `NUM_SLV`: one-hot request to the selected slave.
- `s_we` out 1: latched write enable, shared by all slaves.
- `s_addr` out 32: latched address, shared.
- `s_wd` out 32: latched write data, shared.
- `s_rd` in `NUM_SLV`*32: slave read data; slot i occupies bits [32i+31:32i].
- `s_ack` in `NUM_SLV`: per-slave acknowledge.
- `err_addr` out 32: address of the most recent errored access.
- `err_cnt` out 8: errored-access count; saturates at 255.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, `cpu_req`=1: latch `cpu_we`, `cpu_addr` and `cpu_wd` into `s_we`, `s_addr` and `s_wd`.
  - Decode the slot; clear the timer.
  - Slot < `NUM_SLV`: go to ACCESS.
  - Slot ≥ `NUM_SLV` (unmapped, only possible when `NUM_SLV` is not a power of 2): go directly to DONE with error.
- ACCESS:
  - `s_req[slot]` = 1 for every ACCESS cycle; all other `s_req` bits = 0.
  - The timer increments each cycle.
  - `s_ack` bits of non-selected slots are ignored.
- `s_ack[slot]`=1 at an edge while in ACCESS: go to DONE, no error.
  - Read: `cpu_rd` ← `s_rd[slot]`.
  - Write: `cpu_rd` is unchanged.
- Timeout, when the timer reaches `TIMEOUT` with no ack:
  - Go to DONE with error.
  - Read: `cpu_rd` ← 32'hDEAD_BEEF.
  - `err_addr` ← `s_addr`; `err_cnt` += 1, saturating at 255.
- An unmapped access updates `cpu_rd`, `err_addr` and `err_cnt` exactly as a timeout does.
- Ack arriving on the same edge the timer would reach `TIMEOUT`: the ack wins and no error is raised.
- DONE: `cpu_ready` = 1 for this single cycle; `cpu_err` = error flag. Next state is always IDLE.
- `cpu_req` is ignored in ACCESS and DONE. The CPU must drop `cpu_req` after seeing `cpu_ready`; a request still high in IDLE starts a new access.
- `s_we`, `s_addr` and `s_wd` stay stable from ACCESS entry through DONE.

## Timing
- Reset: state IDLE; `cpu_rd`, `s_addr`, `s_wd`, `err_addr` = 0; `cpu_ready`, `cpu_err`, `s_req`, `s_we` = 0; `err_cnt` = 0; timer = 0.
- All outputs are registered; no combinational path from any input to any output.
- Minimum latency: request sampled at edge k → `s_req` high in cycle k+1 → ack at edge k+1 → `cpu_ready` high in cycle k+2. An access therefore occupies 3 cycles including the DONE cycle.
- Ack after n ACCESS cycles (1 ≤ n ≤ `TIMEOUT`): `cpu_ready` goes high n+1 cycles after the request edge.
- Timeout: `cpu_ready`=1 and `cpu_err`=1 `TIMEOUT`+1 cycles after the request edge.
- Unmapped access: `cpu_ready`=1 and `cpu_err`=1 in the cycle after the request edge.
- Reset during ACCESS or DONE:
  - Next cycle is IDLE with all `s_req` low.
  - No `cpu_ready` pulse is produced.
  - `err_cnt` and `err_addr` return to 0.

## Test plan
- Read slot 2, slave acks on the first ACCESS cycle with `s_rd` = 32'h1234_5678 → `s_req` = 4'b0100 for one cycle; `cpu_ready` pulses at k+2; `cpu_rd` = 32'h1234_5678; `cpu_err` = 0.
- Write addr 32'h0000_0304 (slot 3), data 32'hA5A5_A5A5, ack delayed 5 cycles → `s_addr`/`s_wd` held stable throughout; `cpu_ready` at k+6; `cpu_rd` unchanged.
- Read slot 1, no ack, `TIMEOUT`=15 → `cpu_ready`=1, `cpu_err`=1 at k+16; `cpu_rd` = 32'hDEAD_BEEF; `err_addr` = request address; `err_cnt` = 1.
- Ack on exactly the 15th ACCESS cycle → no error; ack from slot 0 while slot 1 is selected → ignored, ends in timeout.
- `NUM_SLV`=3, access to slot 3 → error pulse at k+1 with no `s_req` ever asserted; 256 timeouts → `err_cnt` = 255.
- Assert `rst` during cycle 4 of a delayed access → `s_req` drops next cycle; no `cpu_ready`; `err_cnt` = 0; a following normal read completes correctly.
